pc_next_seq: RTL and testbench

- Next-PC sequencer. Consumes the current PC from the PC register and computes the PC_Next value that register loads each cycle.
- Owns the fetch request handshake to instruction memory.
- Applies branch/jump redirects from EX and generates pipeline flush strobes.
- Holds a redirect that arrives while a fetch is still waiting for a grant, and applies it once the outstanding fetch completes.

---
 rtl/pc_next_seq_pkg.sv | 16 +
 rtl/pc_next_seq_if.sv | 32 +++
 rtl/pc_redirect_cnt.sv | 18 +
 rtl/pc_next_seq.sv | 112 +++++++++++
 tb/tb_pc_next_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pc_next_seq_pkg.sv
// Shared fetch-pipeline constants and the next-PC sequencer state encoding.
// Also reused by the PC register and the branch unit.
package pc_next_seq_pkg;

    localparam int          PC_XLEN        = 32;
    localparam int          PC_INSTR_BYTES = 4;
    localparam int          PC_CNT_W       = 16;
    localparam logic [31:0] PC_RESET       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_PEND     = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_seq_if.sv
// Sequencer-side bundle: PC register link, EX redirect, hazard stall,
// fetch handshake, flushes and redirect status.
interface pc_next_seq_if
    import pc_next_seq_pkg::*;
#(
    parameter int XLEN  = PC_XLEN,
    parameter int CNT_W = PC_CNT_W
);
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  pc_next_o;
    logic             stall_i;
    logic             redirect_valid_i;
    logic [XLEN-1:0]  redirect_target_i;
    logic             imem_req_o;
    logic             imem_gnt_i;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             misalign_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        input  pc_i, stall_i, redirect_valid_i, redirect_target_i, imem_gnt_i,
        output pc_next_o, imem_req_o, flush_if_id_o, flush_id_ex_o,
               misalign_o, redirect_cnt_o
    );

    modport slave (
        output pc_i, stall_i, redirect_valid_i, redirect_target_i, imem_gnt_i,
        input  pc_next_o, imem_req_o, flush_if_id_o, flush_id_ex_o,
               misalign_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_redirect_cnt.sv
// Saturating event counter for accepted redirects; sticks at all-ones.
module pc_redirect_cnt
    import pc_next_seq_pkg::*;
#(
    parameter int CNT_W = PC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc_en && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pc_next_seq.sv
// Next-PC sequencer: sequential fetch, stall hold, EX redirects with flushes,
// and parking of a redirect that lands while a fetch is still ungranted.
module pc_next_seq
    import pc_next_seq_pkg::*;
#(
    parameter int              XLEN        = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = PC_RESET,
    parameter int              INSTR_BYTES = PC_INSTR_BYTES,
    parameter int              CNT_W       = PC_CNT_W
) (
    input logic          clk,
    input logic          rst,
    pc_next_seq_if.master bus
);
    localparam logic [1:0] RUN      = ST_RUN;
    localparam logic [1:0] WAIT_GNT = ST_WAIT_GNT;
    localparam logic [1:0] PEND     = ST_PEND;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] tgt, pc_seq, pc_next;
    logic            redir, gnt, stall;
    logic            req, fl_ifid, fl_idex;
    logic            misalign_q;

    assign redir  = bus.redirect_valid_i;
    assign gnt    = bus.imem_gnt_i;
    assign stall  = bus.stall_i;
    assign tgt    = {bus.redirect_target_i[XLEN-1:2], 2'b00};
    assign pc_seq = bus.pc_i + XLEN'(INSTR_BYTES);

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pc_next    = bus.pc_i;
        req        = 1'b0;
        fl_ifid    = 1'b0;
        fl_idex    = 1'b0;
        case (state_q)
            RUN: begin
                req = !stall;
                if (redir) begin
                    pc_next = tgt;
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                end else if (!stall) begin
                    if (gnt) pc_next = pc_seq;
                    else     state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                // Outstanding request must stay up with a stable address.
                req = 1'b1;
                if (redir) begin
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    if (gnt) begin
                        pc_next = tgt;
                        state_d = RUN;
                    end else begin
                        pend_tgt_d = tgt;
                        state_d    = PEND;
                    end
                end else if (gnt) begin
                    pc_next = stall ? bus.pc_i : pc_seq;
                    state_d = RUN;
                end
            end
            PEND: begin
                req = 1'b1;
                if (redir) begin
                    pend_tgt_d = tgt;
                    fl_ifid    = 1'b1;
                    fl_idex    = 1'b1;
                end
                if (gnt) begin
                    // The granted word belongs to the old path; drop it.
                    pc_next = redir ? tgt : pend_tgt_q;
                    fl_ifid = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            if (redir && (bus.redirect_target_i[1:0] != 2'b00))
                misalign_q <= 1'b1;
        end
    end

    pc_redirect_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (redir),
        .cnt    (bus.redirect_cnt_o)
    );

    assign bus.pc_next_o     = rst ? RESET_PC : pc_next;
    assign bus.imem_req_o    = !rst && req;
    assign bus.flush_if_id_o = !rst && fl_ifid;
    assign bus.flush_id_ex_o = !rst && fl_idex;
    assign bus.misalign_o    = misalign_q;
endmodule

// File: tb/tb_pc_next_seq.sv
// Bench for pc_next_seq: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the fetch/redirect rules.
module tb_pc_next_seq;
    import pc_next_seq_pkg::*;

    localparam int TCW = 4;
    localparam int CMAX = (1 << TCW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_next_seq_if #(.XLEN(PC_XLEN), .CNT_W(TCW)) bus();

    pc_next_seq #(
        .XLEN(PC_XLEN), .RESET_PC(PC_RESET),
        .INSTR_BYTES(PC_INSTR_BYTES), .CNT_W(TCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: fetch outstanding / redirect parked behind an ungranted fetch.
    bit          m_wait, m_pend, m_mis;
    logic [31:0] m_ptgt, pc_reg;
    int          m_cnt;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit rv,
                        input logic [31:0] rt, input bit g);
        logic [31:0] tgt, e_pc;
        bit          e_req, e_fif, e_fie;
        @(negedge clk);
        rst                   = r;
        bus.pc_i              = pc_reg;
        bus.stall_i           = st;
        bus.redirect_valid_i  = rv;
        bus.redirect_target_i = rt;
        bus.imem_gnt_i        = g;
        if (r) begin
            m_wait = 0; m_pend = 0; m_ptgt = '0; m_mis = 0; m_cnt = 0;
        end
        tgt   = rt & 32'hFFFF_FFFC;
        e_pc  = pc_reg;
        e_req = 0; e_fif = 0; e_fie = 0;
        if (r) begin
            e_pc = PC_RESET;
        end else if (m_pend) begin
            e_req = 1; e_fie = rv; e_fif = rv || g;
            if (g) e_pc = rv ? tgt : m_ptgt;
        end else if (m_wait) begin
            e_req = 1; e_fif = rv; e_fie = rv;
            if (g) e_pc = rv ? tgt : (st ? pc_reg : pc_reg + 32'd4);
        end else begin
            e_req = !st; e_fif = rv; e_fie = rv;
            if (rv) e_pc = tgt;
            else if (!st && g) e_pc = pc_reg + 32'd4;
        end
        #1;
        chk("pc_next",  bus.pc_next_o,            e_pc);
        chk("imem_req", 32'(bus.imem_req_o),      32'(e_req));
        chk("flush_if", 32'(bus.flush_if_id_o),   32'(e_fif));
        chk("flush_ex", 32'(bus.flush_id_ex_o),   32'(e_fie));
        chk("misalign", 32'(bus.misalign_o),      32'(m_mis));
        chk("cnt",      32'(bus.redirect_cnt_o),  32'(m_cnt));
        @(posedge clk);
        if (!r) begin
            if (rv) begin
                if (m_cnt < CMAX) m_cnt++;
                if (rt[1:0] != 2'b00) m_mis = 1;
            end
            if (m_pend) begin
                if (rv) m_ptgt = tgt;
                m_pend = !g;
            end else if (m_wait) begin
                if (g) m_wait = 0;
                else if (rv) begin m_wait = 0; m_pend = 1; m_ptgt = tgt; end
            end else begin
                m_wait = !rv && !st && !g;
            end
        end
        pc_reg = e_pc;
    endtask

    initial begin
        pc_reg = '0;
        bus.pc_i = '0; bus.stall_i = 0; bus.redirect_valid_i = 0;
        bus.redirect_target_i = '0; bus.imem_gnt_i = 0;

        // Reset, then straight-line fetch 0,4,8,C
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        chk("seq_pc", pc_reg, 32'h10);

        // Stall hold at 0x10 then advance
        pc_reg = 32'h10;
        repeat (3) step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("post_stall_pc", pc_reg, 32'h14);

        // Redirect beats stall
        step(0, 1, 1, 32'h100, 1);
        chk("redir_pc", pc_reg, 32'h100);

        // Ungranted fetch at 0x20, redirect parks, applied on grant
        pc_reg = 32'h20;
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h80, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pend_pc", pc_reg, 32'h80);

        // Wraparound of the sequential increment
        pc_reg = 32'hFFFF_FFFC;
        step(0, 0, 0, 0, 1);
        chk("wrap_pc", pc_reg, 32'h0);

        // Misaligned target: sticky until reset
        step(0, 0, 1, 32'h0000_0102, 1);
        chk("mis_pc", pc_reg, 32'h100);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("mis_sticky", 32'(bus.misalign_o), 32'd1);
        step(1, 0, 0, 0, 1);
        chk("mis_cleared", 32'(bus.misalign_o), 32'd0);

        // Saturate the counter, then reset while a target is parked
        for (int i = 0; i < CMAX + 2; i++) step(0, 0, 1, 32'h200 + 32'(i * 4), 1);
        chk("cnt_sat", 32'(bus.redirect_cnt_o), 32'(CMAX));
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h400, 0);
        step(1, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("no_pend_after_rst", pc_reg, 32'hC);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rt;
            rt = $urandom();
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) pc_reg = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 rt,
                 $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
